// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default sizing for the graph-pipeline memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int PKG_NUM_REQ   = 4;
    localparam int PKG_ADDR_W    = 32;
    localparam int PKG_DATA_W    = 64;
    localparam int PKG_MAX_OUTST = 8;

    localparam int REQ_ID_W = $clog2(PKG_NUM_REQ);

    typedef logic [PKG_DATA_W-1:0] pipeline_data_t;
    typedef logic [REQ_ID_W-1:0]   req_id_t;

    typedef struct packed {
        logic                  we;
        logic [PKG_ADDR_W-1:0] addr;
        logic [PKG_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter_tag_fifo.sv
// In-order FIFO of requester ids; the head names the owner of the next memory response.
module mem_port_arbiter_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [W-1:0]           i_data,
    input  logic                   i_pop,
    output logic [W-1:0]           o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_head];

    // Storage and pointers; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {W{1'b0}};
            end
            r_head  <= {PW{1'b0}};
            r_tail  <= {PW{1'b0}};
            r_count <= {CW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_tail] <= i_data;
                r_tail        <= r_tail + PW'(1);
            end
            if (w_do_pop) begin
                r_head <= r_head + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port among pipeline stages, with a
// single request slot and an in-order tag FIFO that routes responses back.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = PKG_NUM_REQ,
    parameter int ADDR_W    = PKG_ADDR_W,
    parameter int DATA_W    = PKG_DATA_W,
    parameter int MAX_OUTST = PKG_MAX_OUTST
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_REQ-1:0]          resp_complete,
    output logic [DATA_W-1:0]           resp_data,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic                        mem_resp_valid,
    input  logic [DATA_W-1:0]           mem_resp_data,
    output logic [$clog2(MAX_OUTST):0]  outstanding,
    output logic                        err_unexp_resp
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTST) + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } slot_t;

    logic [ID_W-1:0]  r_rr_ptr;
    logic             r_slot_valid;
    slot_t            r_slot;
    logic             r_err;

    int               w_idx;
    logic             w_found;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W-1:0]  w_next_ptr;
    slot_t            w_slot_in;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [ID_W-1:0]  w_head_tag;
    logic [CNT_W-1:0] w_count;

    // Priority scan starting at the rotation pointer, wrapping past the last stage
    always_comb begin
        w_found  = 1'b0;
        w_winner = {ID_W{1'b0}};
        w_idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = int'(r_rr_ptr) + k;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end else begin
                w_idx = w_idx;
            end
            if (!w_found && req_valid[ID_W'(w_idx)]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end else begin
                w_found  = w_found;
                w_winner = w_winner;
            end
        end
    end

    // Winner's request fields and the pointer position just after it
    always_comb begin
        w_slot_in = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == ID_W'(i)) begin
                w_slot_in.we    = req_we[i];
                w_slot_in.addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_slot_in.wdata = req_wdata[i*DATA_W +: DATA_W];
            end else begin
                w_slot_in = w_slot_in;
            end
        end
        if (w_winner == ID_W'(NUM_REQ - 1)) begin
            w_next_ptr = {ID_W{1'b0}};
        end else begin
            w_next_ptr = w_winner + ID_W'(1);
        end
    end

    // Full check uses the pre-pop count, so a same-cycle response never frees a tag
    assign w_slot_free = !r_slot_valid || mem_req_ready;
    assign w_accept    = reset && w_found && w_slot_free && !w_full;
    assign w_pop       = mem_resp_valid && !w_empty;

    // Grant and response-routing strobes
    always_comb begin
        req_ready     = {NUM_REQ{1'b0}};
        resp_complete = {NUM_REQ{1'b0}};
        resp_data     = {DATA_W{1'b0}};
        if (w_accept) begin
            req_ready[w_winner] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
        if (w_pop) begin
            resp_complete[w_head_tag] = 1'b1;
            resp_data                 = mem_resp_data;
        end else begin
            resp_data = {DATA_W{1'b0}};
        end
    end

    // Request slot and rotation pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr     <= {ID_W{1'b0}};
            r_slot_valid <= 1'b0;
            r_slot       <= '0;
        end else if (w_accept) begin
            r_rr_ptr     <= w_next_ptr;
            r_slot_valid <= 1'b1;
            r_slot       <= w_slot_in;
        end else if (mem_req_ready) begin
            r_slot_valid <= 1'b0;
        end else begin
            r_slot_valid <= r_slot_valid;
        end
    end

    // Sticky flag for a response with no tag to claim it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (mem_resp_valid && w_empty) begin
            r_err <= 1'b1;
        end else begin
            r_err <= r_err;
        end
    end

    mem_port_arbiter_tag_fifo #(
        .DEPTH (MAX_OUTST),
        .W     (ID_W)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_accept),
        .i_data  (w_winner),
        .i_pop   (w_pop),
        .o_head  (w_head_tag),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign mem_req_valid  = r_slot_valid;
    assign mem_we         = r_slot.we;
    assign mem_addr       = r_slot.addr;
    assign mem_wdata      = r_slot.wdata;
    assign outstanding    = w_count;
    assign err_unexp_resp = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based reference model.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int MO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_we, req_ready, resp_complete;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   resp_data, mem_wdata, mem_resp_data;
    logic            mem_req_valid, mem_req_ready, mem_we, mem_resp_valid, err_unexp_resp;
    logic [AW-1:0]   mem_addr;
    logic [3:0]      outstanding;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .resp_complete(resp_complete), .resp_data(resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data), .outstanding(outstanding), .err_unexp_resp(err_unexp_resp)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: rotation start, slot contents, queue of owners, error flag
    int            m_rr;
    bit            m_slot;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    int            q[$];
    bit            m_err;

    // Outputs captured at the last sample point
    logic [N-1:0]  s_ready, s_complete;
    logic [DW-1:0] s_rdata, s_mwdata;
    logic [AW-1:0] s_maddr;
    logic [3:0]    s_out;
    logic          s_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_rr = 0; m_slot = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_err = 0;
        q.delete();
    endtask

    // Sample 1ns after inputs change (away from the rising edge), compare, advance the model
    task automatic step();
        int           win;
        bit           acc, pop;
        logic [N-1:0] er, ec;
        logic [DW-1:0] ed;
        #1;
        if (!reset) model_clear();
        win = -1;
        for (int k = 0; k < N; k++)
            if (win < 0 && req_valid[(m_rr + k) % N]) win = (m_rr + k) % N;
        acc = reset && (win >= 0) && (!m_slot || mem_req_ready) && (q.size() < MO);
        pop = reset && mem_resp_valid && (q.size() > 0);
        er  = acc ? (4'b0001 << win) : 4'b0000;
        ec  = pop ? (4'b0001 << q[0]) : 4'b0000;
        ed  = pop ? mem_resp_data : 64'h0;
        s_ready = req_ready; s_complete = resp_complete; s_rdata = resp_data;
        s_maddr = mem_addr; s_mwdata = mem_wdata; s_out = outstanding; s_err = err_unexp_resp;
        chk("req_ready", req_ready, er);
        chk("resp_complete", resp_complete, ec);
        chk("resp_data", resp_data, ed);
        chk("mem_req_valid", mem_req_valid, m_slot);
        chk("outstanding", outstanding, q.size());
        chk("err_unexp_resp", err_unexp_resp, m_err);
        if (m_slot || !reset) begin
            chk("mem_we", mem_we, m_we);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
        end
        if (reset) begin
            if (mem_resp_valid && q.size() == 0) m_err = 1;
            if (pop) void'(q.pop_front());
            if (acc) begin
                q.push_back(win);
                m_slot  = 1;
                m_we    = req_we[win];
                m_addr  = req_addr[win*AW +: AW];
                m_wdata = req_wdata[win*DW +: DW];
                m_rr    = (win + 1) % N;
            end else if (mem_req_ready) begin
                m_slot = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input bit v, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i] = v; req_we[i] = we; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d;
    endtask

    task automatic drain();
        req_valid = '0; mem_req_ready = 1'b1;
        for (int g = 0; g < 20 && q.size() > 0; g++) begin
            mem_resp_valid = 1'b1; mem_resp_data = {$urandom, $urandom};
            step();
        end
        mem_resp_valid = 1'b0;
        step();
    endtask

    int exp_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        model_clear();
        reset = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

        // 1: reset with random requests, everything held at zero
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'($urandom); mem_req_ready = 1'($urandom); step();
        end
        chk("rst_req_ready", s_ready, 4'b0000);
        chk("rst_outstanding", s_out, 4'd0);

        // 2: round-robin with everyone requesting
        reset = 1'b1; mem_req_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, 32'h1000 + 32'(i*16), 64'(i) + 64'h5000);
        for (int j = 0; j < 6; j++) begin
            step();
            if (j < 5) chk("rr_grant", s_ready, 4'b0001 << exp_seq[j]);
            if (j > 0) chk("rr_addr", s_maddr, 32'h1000 + 32'(exp_seq[j-1]*16));
        end
        drain();

        // 3: stall with a full slot
        set_req(0, 1'b1, 1'b1, 32'hA000, 64'h1111); mem_req_ready = 1'b1; step();
        chk("stall_first", s_ready, 4'b0001);
        req_valid[0] = 1'b0; set_req(1, 1'b1, 1'b0, 32'hB000, 64'h2222); mem_req_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk("stall_ready", s_ready, 4'b0000);
            chk("stall_addr", s_maddr, 32'hA000);
            chk("stall_wdata", s_mwdata, 64'h1111);
        end
        mem_req_ready = 1'b1; step();
        chk("stall_release", s_ready, 4'b0010);
        req_valid = '0; step();
        chk("stall_next_addr", s_maddr, 32'hB000);
        drain();

        // 4: tag FIFO full, same-cycle response does not free a tag
        req_valid = 4'b1111; mem_req_ready = 1'b1;
        for (int c = 0; c < MO; c++) step();
        mem_resp_valid = 1'b1; mem_resp_data = 64'h77; step();
        chk("full_count", s_out, 4'd8);
        chk("full_no_grant", s_ready, 4'b0000);
        chk("full_pop", 64'(|s_complete), 64'd1);
        mem_resp_valid = 1'b0; step();
        chk("full_grant_next", 64'(s_ready != 4'b0000), 64'd1);
        chk("full_count_after", s_out, 4'd7);
        drain();

        // 5: response routing
        set_req(2, 1'b1, 1'b0, 32'h40, 64'h0); step();
        req_valid = '0; set_req(1, 1'b1, 1'b0, 32'h80, 64'h0); step();
        chk("route_addr0", s_maddr, 32'h40);
        req_valid = '0; step();
        chk("route_addr1", s_maddr, 32'h80);
        mem_resp_valid = 1'b1; mem_resp_data = 64'hAAAA; step();
        chk("route_c0", s_complete, 4'b0100);
        chk("route_d0", s_rdata, 64'hAAAA);
        mem_resp_data = 64'hBBBB; step();
        chk("route_c1", s_complete, 4'b0010);
        chk("route_d1", s_rdata, 64'hBBBB);
        mem_resp_valid = 1'b0; step();

        // Random traffic obeying the hold-until-ready rule; responses only for issued requests
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_valid[i] || s_ready[i])
                    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom), $urandom, {$urandom, $urandom});
            mem_req_ready  = ($urandom_range(0, 3) != 0);
            mem_resp_valid = ((q.size() - (m_slot ? 1 : 0)) > 0) && ($urandom_range(0, 2) == 0);
            mem_resp_data  = {$urandom, $urandom};
            step();
        end

        // Reset mid-operation drops in-flight tags
        reset = 1'b0; mem_resp_valid = 1'b0; step(); step();
        reset = 1'b1; req_valid = '0; step();

        // 6: unexpected response sets the sticky error
        mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD; step();
        chk("err_no_complete", s_complete, 4'b0000);
        mem_resp_valid = 1'b0; step();
        chk("err_set", s_err, 1'b1);
        for (int c = 0; c < 3; c++) step();
        chk("err_held", s_err, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
